// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over the shared datapath. Build option: ILLEGAL_TRAP_EN.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               reg_write,
  output logic [2:0]         imm_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         result_src,
  output logic               instr_retired,
  output logic               trap,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_TRAP
  } state_t;
`else
  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI
  } state_t;
`endif

  typedef enum logic [1:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_FUNCT
  } alu_op_t;

  state_t  state_q;
  state_t  state_d;
  alu_op_t alu_op;

  logic pc_write_raw;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;
  logic retire_raw;
  logic trap_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    trap_raw      = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALU_OP_ADD;
    result_src    = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Computes old_pc + imm now so branch/jal targets are ready later.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_OP_SUB;
        case (funct3)
          3'b000:  pc_write_raw = zero;
          3'b001:  pc_write_raw = ~zero;
          default: pc_write_raw = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_JALR: begin
        // Target rd1 + imm lands in alu_out; JAL then loads it and forms the link.
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JAL;
      end
      S_JAL: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write_raw = 1'b1;
        state_d      = S_ALUWB;
      end
      S_LUI: begin
        result_src    = 2'b11;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        trap_raw = 1'b1;
        state_d  = S_TRAP;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign retire_raw = (state_q != S_FETCH) && (state_d == S_FETCH);

  // Reset gates every enable so an aborted instruction leaves no partial write.
  assign pc_write      = pc_write_raw  & rst_n;
  assign ir_write      = ir_write_raw  & rst_n;
  assign mem_write     = mem_write_raw & rst_n;
  assign reg_write     = reg_write_raw & rst_n;
  assign instr_retired = retire_raw    & rst_n;
  assign trap          = trap_raw      & rst_n;
  assign state         = state_q;

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALU_OP_ADD: alu_control = 3'b000;
      ALU_OP_SUB: alu_control = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alu_control = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b100:  alu_control = 3'b100;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (opcode)
      OP_STORE:  imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_JAL:    imm_src = 3'b011;
      OP_LUI:    imm_src = 3'b100;
      default:   imm_src = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: a per-instruction cycle model fills
// an expected queue, a negedge monitor compares every cycle's control outputs.
module tb_multicycle_controller;

  localparam int W = 19;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] result_src;
  logic       instr_retired, trap;
  logic [3:0] state;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .imm_src(imm_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .result_src(result_src), .instr_retired(instr_retired), .trap(trap),
    .state(state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n = 1'b0; opcode = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] act_v, exp_v;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {pc_write, ir_write, adr_src, mem_write, reg_write, imm_src,
               alu_src_a, alu_src_b, alu_control, result_src, instr_retired, trap};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL ctrl_vec #%0d op=%b f3=%b rst_n=%b mr=%b act=%b exp=%b (pcw irw adr mw rw imm a b alu res ret trap)",
                 vectors, opcode, funct3, rst_n, mem_ready, act_v, exp_v);
      end
    end
  end

  // reference model helpers
  function automatic logic [W-1:0] mk(input logic pcw, input logic irw, input logic adr,
                                      input logic mw, input logic rw, input logic [2:0] imm,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] alu, input logic [1:0] res,
                                      input logic ret, input logic trp);
    return {pcw, irw, adr, mw, rw, imm, a, b, alu, res, ret, trp};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7);
    case (f3)
      3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // driver tasks
  logic [6:0] i_op;
  logic [2:0] i_f3;
  logic       i_f7, i_z;
  int         cyc_n, abort_at;
  bit         aborted;

  task automatic drive_cycle(input logic rst, input logic mr, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    rst_n = rst; mem_ready = mr; opcode = i_op; funct3 = i_f3;
    funct7b5 = i_f7; zero = i_z;
    exp_q.push_back(e);
  endtask

  task automatic reset_cycle();
    drive_cycle(1'b0, rb(), mk(0, 0, 0, 0, 0, imm_of(i_op), 2'b00, 2'b10, 3'b000, 2'b10, 0, 0));
  endtask

  task automatic cyc(input logic mr, input logic [W-1:0] e);
    if (aborted) return;
    if (cyc_n == abort_at) begin
      reset_cycle();
      aborted = 1'b1;
    end else begin
      drive_cycle(1'b1, mr, e);
    end
    cyc_n++;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int fstall, input int mstall, input int ab);
    logic [2:0] imm;
    logic       br;
    i_op = op; i_f3 = f3; i_f7 = f7; i_z = z;
    cyc_n = 0; abort_at = ab; aborted = 1'b0;
    imm = imm_of(op);
    repeat (fstall) cyc(1'b0, mk(0, 0, 0, 0, 0, imm, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0));
    cyc(1'b1, mk(1, 1, 0, 0, 0, imm, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0));
    cyc(rb(), mk(0, 0, 0, 0, 0, imm, 2'b01, 2'b01, 3'b000, 2'b00,
                 logic'(!is_legal(op) && !TRAP_BUILD), 0));
    if (!is_legal(op)) begin
      if (TRAP_BUILD) begin
        repeat (3) cyc(rb(), mk(0, 0, 0, 0, 0, imm, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1));
        if (!aborted) reset_cycle();
      end
      return;
    end
    case (op)
      7'b0000011: begin
        cyc(rb(), mk(0, 0, 0, 0, 0, imm, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
        repeat (mstall) cyc(1'b0, mk(0, 0, 1, 0, 0, imm, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
        cyc(1'b1, mk(0, 0, 1, 0, 0, imm, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
        cyc(rb(), mk(0, 0, 0, 0, 1, imm, 2'b00, 2'b00, 3'b000, 2'b01, 1, 0));
      end
      7'b0100011: begin
        cyc(rb(), mk(0, 0, 0, 0, 0, imm, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
        repeat (mstall) cyc(1'b0, mk(0, 0, 1, 1, 0, imm, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
        cyc(1'b1, mk(0, 0, 1, 1, 0, imm, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
      end
      7'b0110011, 7'b0010011: begin
        cyc(rb(), mk(0, 0, 0, 0, 0, imm, 2'b10, (op == 7'b0010011) ? 2'b01 : 2'b00,
                     funct_alu(op, f3, f7), 2'b00, 0, 0));
        cyc(rb(), mk(0, 0, 0, 0, 1, imm, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
      end
      7'b1100011: begin
        br = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
        cyc(rb(), mk(br, 0, 0, 0, 0, imm, 2'b10, 2'b00, 3'b001, 2'b00, 1, 0));
      end
      7'b1101111, 7'b1100111: begin
        if (op == 7'b1100111)
          cyc(rb(), mk(0, 0, 0, 0, 0, imm, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
        cyc(rb(), mk(1, 0, 0, 0, 0, imm, 2'b01, 2'b10, 3'b000, 2'b00, 0, 0));
        cyc(rb(), mk(0, 0, 0, 0, 1, imm, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0));
      end
      default: begin
        cyc(rb(), mk(0, 0, 0, 0, 1, imm, 2'b00, 2'b00, 3'b000, 2'b11, 1, 0));
      end
    endcase
  endtask

  logic [6:0] legal_ops[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

  initial begin
    logic [6:0] op;
    int         fs, ms, ab;
    i_op = 7'b0000011; i_f3 = 3'b000; i_f7 = 1'b0; i_z = 1'b0;
    cyc_n = 0; abort_at = -1; aborted = 1'b0;
    reset_cycle();
    // directed cases
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, -1);  // lw, no stalls
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3, -1);  // sw, 3 stall cycles
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, -1);  // beq taken
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, -1);  // bne not taken
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1, 0, -1);  // sub
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, -1);  // addi, funct7b5 ignored
    run_instr(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0, -1);  // andi
    run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0, -1);  // jalr
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 2, 0, -1);  // jal after fetch stall
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, -1);  // lui
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1);  // illegal
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, -1);
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 5, 4);   // reset during sw stall
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 4);   // reset in MEMWB
    // randomized mix
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        do op = 7'($urandom_range(0, 127)); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      fs = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      ms = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 5) : -1;
      run_instr(op, 3'($urandom_range(0, 7)), rb(), rb(), fs, ms, ab);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: act=%0d left exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core; sequences the shared datapath (one memory, one ALU, one immediate extender) across multiple cycles per instruction.
- Drives the immediate extender's imm_src select, ALU operand/function selects, result mux, and all architectural write enables.
- Waits on a memory-ready handshake for every memory access.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, bne, jal, jalr, lui.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction bits [6:0] from the instruction register.
- funct3  in  3  instruction bits [14:12].
- funct7b5  in  1  instruction bit 30.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write  out  1  PC register load enable.
- ir_write  out  1  instruction register and old_pc load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = result.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- imm_src  out  3  immediate type select: 000 I, 001 S, 010 B, 011 J, 100 U.
- alu_src_a  out  2  ALU operand A select: 00 PC, 01 old_pc, 10 rd1.
- alu_src_b  out  2  ALU operand B select: 00 rd2, 01 imm_ext, 10 constant 4.
- alu_control  out  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- result_src  out  2  result mux select: 00 alu_out, 01 read data, 10 alu_result, 11 imm_ext.
- instr_retired  out  1  one-cycle pulse on the final cycle of each instruction.
- trap  out  1  illegal-instruction halt (see Optional Feature).
- state  out  STATE_W  current state, for debug.

Behaviour:
- Reset:
  - Asynchronous reset puts the FSM in FETCH.
  - While rst_n = 0, pc_write, ir_write, mem_write, reg_write, instr_retired and trap are forced to 0.
- Output timing: all outputs are combinational from the state and inputs (Moore outputs plus the mem_ready and zero qualifiers). Any output not listed for a state is 0 / 00.
- imm_src is decoded from opcode in every state:
  - 0000011, 0010011, 1100111 -> 000.
  - 0100011 -> 001.
  - 1100011 -> 010.
  - 1101111 -> 011.
  - 0110111 -> 100.
  - any other opcode -> 000.
- ALU decode (internal alu_op):
  - alu_op add -> 000.
  - alu_op sub -> 001.
  - alu_op funct, by funct3:
    - 000: sub if opcode[5] & funct7b5, else add.
    - 010: slt.
    - 100: xor.
    - 110: or.
    - 111: and.
    - any other funct3: add.
- States and transitions:
  - FETCH: a=00, b=10, alu_op add, result_src=10. pc_write = ir_write = mem_ready. mem_ready=1 -> DECODE; mem_ready=0 -> stay in FETCH.
  - DECODE: a=01, b=01, alu_op add (branch/jal target). Next state by opcode:
    - lw / sw -> MEMADR.
    - R-type -> EXEC_R.
    - I-ALU -> EXEC_I.
    - branch -> BRANCH.
    - jal -> JAL.
    - jalr -> JALR.
    - lui -> LUI.
    - other -> illegal handling (see Optional Feature).
  - MEMADR: a=10, b=01, alu_op add. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Wait for mem_ready, then -> MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: adr_src=1, result_src=00. mem_write=1 is held until mem_ready, then -> FETCH.
  - EXEC_R: a=10, b=00, alu_op funct -> ALUWB.
  - EXEC_I: a=10, b=01, alu_op funct -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - BRANCH: a=10, b=00, alu_op sub, result_src=00. pc_write = zero when funct3=000 (beq), ~zero when funct3=001 (bne), 0 for any other funct3. Always -> FETCH.
  - JALR: a=10, b=01, alu_op add; no enables asserted -> JAL.
  - JAL: a=01, b=10, alu_op add, result_src=00, pc_write=1 -> ALUWB (ALUWB writes the link value old_pc+4).
  - LUI: result_src=11, reg_write=1 -> FETCH.
- jalr target LSB is not cleared by this block.
- instr_retired = 1 in any non-FETCH state whose next state is FETCH, evaluated with the current mem_ready and opcode.
- Memory stalls: mem_ready may stay low indefinitely. While stalled, all enables other than the held mem_write are 0.
- mem_ready is ignored in every state except FETCH, MEMREAD and MEMWRITE.
- Reset asserted mid-instruction aborts it; no partial write completes after rst_n falls.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE -> TRAP.
  - TRAP asserts trap=1 with all enables 0; it is left only by reset.
  - No instr_retired pulse for the illegal instruction.
- Undefined:
  - An unrecognised opcode in DECODE -> FETCH, executing as a NOP with instr_retired=1.
  - The TRAP state does not exist and trap is tied to 0.

Test Plan:
- lw, opcode 0000011, mem_ready=1 throughout -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles); imm_src=000; reg_write=1 only in MEMWB; instr_retired pulses once.
- sw with mem_ready held low 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, imm_src=001; returns to FETCH after mem_ready=1.
- beq with zero=1, then bne with zero=1 -> pc_write=1 in BRANCH for beq, pc_write=0 for bne; alu_control=001 in BRANCH.
- R-type sub (funct3=000, funct7b5=1) -> alu_control=001 in EXEC_R; I-type addi with funct7b5=1 -> alu_control=000; funct3=111 -> 010.
- jalr -> states JALR, JAL, ALUWB; pc_write=1 only in JAL; reg_write=1 only in ALUWB; imm_src=000.
- opcode 1111111: with ILLEGAL_TRAP_EN, trap=1 until rst_n low, then FETCH with trap=0; without it, return to FETCH with instr_retired=1.
